memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
// Shares the single memory_map port (address/write_data/write_enable/read_data) between two requesters:
// m0 = utoss_riscv core, m1 = program loader / debug master. Round-robin grant, one transaction in flight.
// Sits between the requesters and memory_map in the board top; memory_map is unchanged.
// PARAMETERS
// READ_LATENCY  1  cycles from memory__address valid at a clock edge to memory__read_data valid (1..4)
// PORTS
// clk                     in   1   system clock
// reset_n                 in   1   synchronous, active-low reset
// m0__req_valid           in   1   m0 request pending; hold address/data/we stable until accepted
// m0__req_ready           out  1   m0 request accepted this cycle when valid & ready
// m0__req_address         in   32  byte address (addr_t)
// m0__req_write_data      in   32  write data (data_t)
// m0__req_write_enable    in   4   byte-lane write strobes; 4'b0000 = read
// m0__rsp_valid           out  1   1-cycle pulse: transaction complete, read data valid
// m0__rsp_read_data       out  32  read data, qualified by m0__rsp_valid
// m1__*                   --   --  identical set of 7 signals for requester 1
// memory__address         out  32  to memory_map
// memory__write_data      out  32  to memory_map
// memory__write_enable    out  4   to memory_map
// memory__read_data       in   32  from memory_map
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state IDLE, rr_last=1 (m0 wins first tie), latched addr/data/we/id = 0;
//   all req_ready, rsp_valid, memory__write_enable = 0; memory__address/write_data = 0.
// - FSM IDLE -> ACCESS -> RESP -> IDLE. One outstanding transaction; no pipelining.
// - IDLE: grant combinational. Only m0 valid -> m0; only m1 valid -> m1; both -> requester != rr_last.
//   Granted requester sees req_ready=1 in the same cycle; other req_ready=0. Neither valid -> stay IDLE.
//   On accept: latch address, write_data, write_enable, id; rr_last <= id; cnt <= READ_LATENCY; -> ACCESS.
// - req_ready is 0 in ACCESS and RESP; a request raised during them waits in IDLE arbitration.
// - ACCESS: memory__address/write_data = latched values. memory__write_enable = latched strobes ONLY in
//   first ACCESS cycle (cnt==READ_LATENCY), else 0 -> each write hits memory exactly once.
//   cnt decrements each cycle; cnt==1 -> RESP.
// - RESP: 1 cycle; memory__address held; rsp_valid=1 for the latched id only;
//   rsp_read_data = memory__read_data (pass-through). For writes rsp_valid still pulses (ack); data don't-care.
//   Non-granted requester's rsp_valid stays 0. -> IDLE.
// - Latency: accept at cycle T -> rsp_valid at T+1+READ_LATENCY. Throughput: 1 txn per READ_LATENCY+2 cycles.
// - Fairness: with both requesters continuously valid, grants strictly alternate; no starvation.
// - Responses have no backpressure; requester must take rsp_valid in the pulse cycle.
// - memory__write_enable is 0 in IDLE and RESP regardless of requester inputs (no combinational path
//   from req_* to memory__*).
// - reset_n low mid-ACCESS/RESP: abort, return to IDLE, no rsp_valid; an unissued write is dropped;
//   an issued write is not repeated.
// - rsp_read_data outside rsp_valid: don't-care.
// TESTING
// 1 Reset: hold reset_n=0 3 cycles with m0/m1 valid -> all req_ready, rsp_valid, memory__write_enable = 0.
// 2 m0 write 0x0000_0010 <= 0xDEAD_BEEF, we=4'hF, then read 0x10 -> write_enable=4'hF for exactly 1 cycle;
//   read rsp_valid at T+2 (READ_LATENCY=1), rsp_read_data=0xDEAD_BEEF; m1__rsp_valid stays 0.
// 3 m0 and m1 both valid continuously for 8 txns after reset -> grant order m0,m1,m0,m1,...; 4 each; no gaps
//   beyond READ_LATENCY+2.
// 4 Byte lane: preload 0x1122_3344 at 0x20; m1 write we=4'b0010, data 0x0000_AA00; read -> 0x1122_AA44.
// 5 READ_LATENCY=3: m1 read -> rsp_valid exactly at T+4, write_enable never reasserted in later cycles.
// 6 reset_n low in ACCESS of an m0 read -> no rsp_valid; after release, fresh m1 request granted and completes.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory_map port between two requesters
// (m0 = core, m1 = loader/debug). Round-robin grant, one transaction in flight.
// Each transaction runs IDLE -> ACCESS (READ_LATENCY cycles) -> RESP (1 cycle).
// The write strobe and the response pulse are registered, so nothing from
// the requester inputs reaches memory__* combinationally.

module memory_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0__req_valid,
    output logic        m0__req_ready,
    input  logic [31:0] m0__req_address,
    input  logic [31:0] m0__req_write_data,
    input  logic [3:0]  m0__req_write_enable,
    output logic        m0__rsp_valid,
    output logic [31:0] m0__rsp_read_data,

    input  logic        m1__req_valid,
    output logic        m1__req_ready,
    input  logic [31:0] m1__req_address,
    input  logic [31:0] m1__req_write_data,
    input  logic [3:0]  m1__req_write_enable,
    output logic        m1__rsp_valid,
    output logic [31:0] m1__rsp_read_data,

    output logic [31:0] memory__address,
    output logic [31:0] memory__write_data,
    output logic [3:0]  memory__write_enable,
    input  logic [31:0] memory__read_data
);

    // ST_IDLE   | waiting for a request, combinational round-robin grant
    // ST_ACCESS | latched address on memory, strobes only in the first cycle
    // ST_RESP   | rsp_valid pulse to the owner, read data passed through
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // 3 bits covers latencies 1..4
    localparam int              CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rr_last;
    logic             r_id;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_mem_we;
    logic [1:0]       r_rsp_valid;

    logic             w_grant_valid;
    logic             w_grant_id;
    logic [31:0]      w_req_addr;
    logic [31:0]      w_req_wdata;
    logic [3:0]       w_req_we;

    // Round-robin grant, only offered in IDLE and never while reset is held
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (reset_n && (r_state == ST_IDLE)) begin
            if (m0__req_valid && m1__req_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = ~r_rr_last;
            end else if (m0__req_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (m1__req_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    // Select the granted requester's command for latching
    always_comb begin
        w_req_addr  = m0__req_address;
        w_req_wdata = m0__req_write_data;
        w_req_we    = m0__req_write_enable;
        if (w_grant_id) begin
            w_req_addr  = m1__req_address;
            w_req_wdata = m1__req_write_data;
            w_req_we    = m1__req_write_enable;
        end
    end

    assign m0__req_ready = w_grant_valid & ~w_grant_id;
    assign m1__req_ready = w_grant_valid &  w_grant_id;

    // Transaction FSM with registered memory strobe and response pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rr_last   <= 1'b1;
            r_id        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_we    <= '0;
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid <= '0;
                    r_mem_we    <= '0;
                    if (w_grant_valid) begin
                        r_id      <= w_grant_id;
                        r_rr_last <= w_grant_id;
                        r_addr    <= w_req_addr;
                        r_wdata   <= w_req_wdata;
                        // strobes live for exactly the first ACCESS cycle
                        r_mem_we  <= w_req_we;
                        r_cnt     <= CNT_INIT;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_we <= '0;
                    r_cnt    <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_rsp_valid <= r_id ? 2'b10 : 2'b01;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= '0;
                    r_mem_we    <= '0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_mem_we    <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign memory__address      = r_addr;
    assign memory__write_data   = r_wdata;
    assign memory__write_enable = r_mem_we;

    assign m0__rsp_valid     = r_rsp_valid[0];
    assign m1__rsp_valid     = r_rsp_valid[1];
    assign m0__rsp_read_data = memory__read_data;
    assign m1__rsp_read_data = memory__read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two instances (READ_LATENCY 1 and 3), each with
// a byte-lane memory model, driven by a vector table, hand-written corner
// sequences and a randomized run checked against a transaction-level model.

module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2][2];
    logic        req_ready [2][2];
    logic [31:0] req_addr  [2][2];
    logic [31:0] req_wdata [2][2];
    logic [3:0]  req_we    [2][2];
    logic        rsp_valid [2][2];
    logic [31:0] rsp_data  [2][2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_we    [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] mem  [2][256];
    logic [31:0] pipe [2][3];
    int          we_cnt [2];
    int          cyc = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        memory_arbiter #(.READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk                  (clk),
            .reset_n              (rst_n[g]),
            .m0__req_valid        (req_valid[g][0]),
            .m0__req_ready        (req_ready[g][0]),
            .m0__req_address      (req_addr[g][0]),
            .m0__req_write_data   (req_wdata[g][0]),
            .m0__req_write_enable (req_we[g][0]),
            .m0__rsp_valid        (rsp_valid[g][0]),
            .m0__rsp_read_data    (rsp_data[g][0]),
            .m1__req_valid        (req_valid[g][1]),
            .m1__req_ready        (req_ready[g][1]),
            .m1__req_address      (req_addr[g][1]),
            .m1__req_write_data   (req_wdata[g][1]),
            .m1__req_write_enable (req_we[g][1]),
            .m1__rsp_valid        (rsp_valid[g][1]),
            .m1__rsp_read_data    (rsp_data[g][1]),
            .memory__address      (mem_addr[g]),
            .memory__write_data   (mem_wdata[g]),
            .memory__write_enable (mem_we[g]),
            .memory__read_data    (mem_rdata[g])
        );
        assign mem_rdata[g] = pipe[g][g == 0 ? 0 : 2];
    end

    // Memory model: byte-lane writes, read data valid READ_LATENCY cycles after the address edge
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pipe[d][2] <= pipe[d][1];
            pipe[d][1] <= pipe[d][0];
            pipe[d][0] <= mem[d][mem_addr[d][9:2]];
            if (mem_we[d] != 4'h0) begin
                we_cnt[d] <= we_cnt[d] + 1;
                for (int b = 0; b < 4; b++)
                    if (mem_we[d][b])
                        mem[d][mem_addr[d][9:2]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_in();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        for (int r = 0; r < 2; r++) req_valid[d][r] = 1'b0;
        next_in();
        next_in();
        rst_n[d] = 1'b1;
    endtask

    // One complete transaction on instance d, requester r; starts and ends just after a posedge
    task automatic do_txn(input int d, input int r, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] we,
                          output logic [31:0] rdata, output int lat, output int nwe,
                          output bit other, output bit ok);
        int t_acc;
        int wc0;
        bit got;
        rdata = '0; lat = -1; nwe = 0; other = 1'b0; ok = 1'b0; got = 1'b0; t_acc = 0;
        wc0 = we_cnt[d];
        req_valid[d][r] = 1'b1;
        req_addr[d][r]  = addr;
        req_wdata[d][r] = wdata;
        req_we[d][r]    = we;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[d][r]) begin
                got   = 1'b1;
                t_acc = cyc;
            end
            next_in();
        end
        req_valid[d][r] = 1'b0;
        if (got) begin
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (rsp_valid[d][1-r]) other = 1'b1;
                if (rsp_valid[d][r]) begin
                    ok    = 1'b1;
                    rdata = rsp_data[d][r];
                    lat   = cyc - t_acc;
                end
                next_in();
            end
        end
        next_in();
        nwe = we_cnt[d] - wc0;
    endtask

    typedef struct {
        int          k;
        int          r;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    // Randomized traffic vs. a transaction-level model: who wins, when the
    // response arrives, what a read returns, and the single write-strobe cycle.
    task automatic run_random(input int d, input int ngen);
        logic [31:0] ref_mem [int];
        exp_t        eq [$];
        exp_t        e;
        bit          pend [2];
        logic [31:0] p_addr [2];
        logic [31:0] p_wdata [2];
        logic [3:0]  p_we [2];
        logic [31:0] word;
        logic [3:0]  issue_we;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rsp;
        int          rr, free_k, issue_k, lat, win;
        lat = (d == 0) ? 1 : 3;
        do_reset(d);
        rr = 1; free_k = 0; issue_k = -1; issue_we = 4'h0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; p_addr[r] = '0; p_wdata[r] = '0; p_we[r] = '0;
        end
        for (int k = 0; k < ngen + 30; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && k < ngen && $urandom_range(0, 2) != 0) begin
                    pend[r]    = 1'b1;
                    p_addr[r]  = 32'h100 + ($urandom_range(0, 15) << 2);
                    p_wdata[r] = $urandom;
                    p_we[r]    = ($urandom_range(0, 4) < 2) ? 4'h0 : 4'($urandom_range(1, 15));
                    if (!ref_mem.exists(p_addr[r])) p_we[r] = 4'hF;
                end
                req_valid[d][r] = pend[r];
                req_addr[d][r]  = p_addr[r];
                req_wdata[d][r] = p_wdata[r];
                req_we[d][r]    = p_we[r];
            end
            @(negedge clk);
            exp_rdy = 2'b00;
            win = -1;
            if (k >= free_k) begin
                if (pend[0] && pend[1]) win = 1 - rr;
                else if (pend[0])       win = 0;
                else if (pend[1])       win = 1;
                if (win >= 0) exp_rdy[win] = 1'b1;
            end
            chk("rnd_ready", 32'({req_ready[d][1], req_ready[d][0]}), 32'(exp_rdy));
            exp_rsp = 2'b00;
            if (eq.size() > 0 && eq[0].k == k) exp_rsp[eq[0].r] = 1'b1;
            chk("rnd_rsp_valid", 32'({rsp_valid[d][1], rsp_valid[d][0]}), 32'(exp_rsp));
            if (exp_rsp != 2'b00) begin
                if (eq[0].rd) chk("rnd_rdata", rsp_data[d][eq[0].r], eq[0].data);
                void'(eq.pop_front());
            end
            chk("rnd_mem_we", 32'(mem_we[d]), 32'((k == issue_k) ? issue_we : 4'h0));
            if (win >= 0) begin
                rr       = win;
                free_k   = k + lat + 2;
                issue_k  = k + 1;
                issue_we = p_we[win];
                e.k  = k + 1 + lat;
                e.r  = win;
                e.rd = (p_we[win] == 4'h0);
                if (!e.rd) begin
                    word = ref_mem.exists(p_addr[win]) ? ref_mem[p_addr[win]] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (p_we[win][b]) word[8*b +: 8] = p_wdata[win][8*b +: 8];
                    ref_mem[p_addr[win]] = word;
                end
                e.data = ref_mem[p_addr[win]];
                eq.push_back(e);
                pend[win] = 1'b0;
            end
            next_in();
        end
        chk("rnd_drained", 32'(eq.size()), 32'h0);
        for (int r = 0; r < 2; r++) req_valid[d][r] = 1'b0;
    endtask

    typedef struct {
        int          d;
        int          r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [11];
        logic [31:0] rd;
        int          lat, nwe, grants, last_t, wc1;
        bit          oth, ok, got, saw;

        vt[0]  = '{0, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vt[1]  = '{0, 0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vt[2]  = '{0, 0, 32'h20, 32'h1122_3344, 4'hF, 32'h0};
        vt[3]  = '{0, 1, 32'h20, 32'h0000_AA00, 4'h2, 32'h0};
        vt[4]  = '{0, 1, 32'h20, 32'h0,         4'h0, 32'h1122_AA44};
        vt[5]  = '{0, 0, 32'h20, 32'h7700_0000, 4'h8, 32'h0};
        vt[6]  = '{0, 0, 32'h20, 32'h0,         4'h0, 32'h7722_AA44};
        vt[7]  = '{1, 1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'h0};
        vt[8]  = '{1, 1, 32'h40, 32'h0,         4'h0, 32'hCAFE_F00D};
        vt[9]  = '{1, 0, 32'h40, 32'h0000_00EE, 4'h1, 32'h0};
        vt[10] = '{1, 1, 32'h40, 32'h0,         4'h0, 32'hCAFE_F0EE};

        // Reset held 3 cycles with both requesters valid: everything quiet
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                req_valid[d][r] = 1'b1;
                req_addr[d][r]  = 32'h10;
                req_wdata[d][r] = 32'h1234_5678;
                req_we[d][r]    = 4'hF;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk($sformatf("reset_quiet_d%0d", d),
                    32'({req_ready[d][1], req_ready[d][0], rsp_valid[d][1], rsp_valid[d][0], mem_we[d]}),
                    32'h0);
        end
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 2; r++) req_valid[d][r] = 1'b0;
        next_in();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        next_in();

        // Directed single transactions from the vector table
        for (int i = 0; i < 11; i++) begin
            do_txn(vt[i].d, vt[i].r, vt[i].addr, vt[i].wdata, vt[i].we, rd, lat, nwe, oth, ok);
            chk($sformatf("vec%0d_handshake", i), 32'(ok), 32'h1);
            chk($sformatf("vec%0d_latency", i), lat, (vt[i].d == 0 ? 1 : 3) + 1);
            chk($sformatf("vec%0d_we_count", i), nwe, (vt[i].we != 4'h0) ? 1 : 0);
            chk($sformatf("vec%0d_other_rsp", i), 32'(oth), 32'h0);
            if (vt[i].we == 4'h0) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
        end

        // Long-latency instance: write strobe must not come back later
        wc1 = we_cnt[1];
        for (int i = 0; i < 6; i++) next_in();
        chk("lat3_no_late_we", we_cnt[1] - wc1, 0);

        // Fairness: both valid continuously, 8 grants alternate m0,m1 with no gaps
        do_reset(0);
        for (int r = 0; r < 2; r++) begin
            req_valid[0][r] = 1'b1;
            req_addr[0][r]  = 32'h10;
            req_we[0][r]    = 4'h0;
        end
        grants = 0;
        last_t = 0;
        for (int i = 0; i < 100 && grants < 8; i++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (req_ready[0][r]) begin
                    chk($sformatf("fair_order_%0d", grants), r, grants % 2);
                    if (grants > 0) chk($sformatf("fair_gap_%0d", grants), cyc - last_t, 3);
                    last_t = cyc;
                    grants++;
                end
            end
            next_in();
        end
        chk("fair_count", grants, 8);
        for (int r = 0; r < 2; r++) req_valid[0][r] = 1'b0;
        for (int i = 0; i < 4; i++) next_in();

        // Reset during ACCESS of an m0 read: no response, then m1 served normally
        req_valid[0][0] = 1'b1;
        req_addr[0][0]  = 32'h10;
        req_we[0][0]    = 4'h0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0][0]) got = 1'b1;
            next_in();
        end
        chk("abort_accept", 32'(got), 32'h1);
        req_valid[0][0] = 1'b0;
        @(negedge clk);
        chk("abort_access_addr", mem_addr[0], 32'h10);
        #1;
        rst_n[0] = 1'b0;
        next_in();
        rst_n[0] = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid[0][0] || rsp_valid[0][1] || mem_we[0] != 4'h0) saw = 1'b1;
            next_in();
        end
        chk("abort_no_rsp", 32'(saw), 32'h0);
        do_txn(0, 1, 32'h10, 32'h0, 4'h0, rd, lat, nwe, oth, ok);
        chk("abort_m1_handshake", 32'(ok), 32'h1);
        chk("abort_m1_latency", lat, 2);
        chk("abort_m1_rdata", rd, 32'hDEAD_BEEF);
        chk("abort_m1_other_rsp", 32'(oth), 32'h0);

        // Randomized traffic on both latencies
        run_random(0, 400);
        run_random(1, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
